// File: rtl/axils_uart_regs_if.sv
// AXI4-Lite channel bundle for the UART register block.
// The slave modport is used by axils_uart_regs and the master modport by its driver.
interface axils_uart_regs_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axils_uart_regs.sv
// AXI4-Lite register block for the UART: baud divisor, control, W1C status,
// RX FIFO with overrun detection, TX holding register and a level interrupt.
module axils_uart_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH         = 8,
    parameter int unsigned RX_FIFO_DEPTH      = 16,
    parameter logic [31:0] BAUD_RESET         = 32'd9600
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    axils_uart_regs_if.slave      s_axi,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [31:0]           baud_div,
    output logic                  irq
);
    localparam int unsigned StrbW = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned PtrW  = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = PtrW + 1;

    typedef enum logic [2:0] {StWrIdle, StWrGotAw, StWrGotW, StWrExec, StWrResp} wr_state_e;
    typedef enum logic {StRdIdle, StRdResp} rd_state_e;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic [2:0]             wr_idx_q;
    logic [31:0]            wdata_q;
    logic [StrbW-1:0]       wstrb_q;
    logic [1:0]             bresp_q;
    logic [31:0]            rdata_q;
    logic [1:0]             rresp_q;
    logic [31:0]            baud_q, baud_d;
    logic [2:0]             ctrl_q, ctrl_d;
    logic                   overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   irq_q, irq_d;
    logic [DATA_WIDTH-1:0]  fifo_mem [RX_FIFO_DEPTH];
    logic [PtrW-1:0]        rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]        count_q, count_d;

    logic aw_hs, w_hs, ar_hs, wr_en, wr_err, rd_err;
    logic flush, ovr_clr, tx_load, pop, push_req, push_do, ovr_set;
    logic rx_not_empty, rx_full;
    logic [2:0]  ar_idx;
    logic [7:0]  rx_level;
    logic [31:0] rd_data;
    logic [C_S_AXI_ADDR_WIDTH-1:0] unused_addr_bits;

    // Only ADDR[4:2] decode; the rest of the address is intentionally ignored.
    assign unused_addr_bits = s_axi.awaddr ^ s_axi.araddr;

    assign s_axi.awready = (wr_state_q == StWrIdle) || (wr_state_q == StWrGotW);
    assign s_axi.wready  = (wr_state_q == StWrIdle) || (wr_state_q == StWrGotAw);
    assign s_axi.bvalid  = (wr_state_q == StWrResp);
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = (rd_state_q == StRdIdle);
    assign s_axi.rvalid  = (rd_state_q == StRdResp);
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    assign aw_hs  = s_axi.awvalid & s_axi.awready;
    assign w_hs   = s_axi.wvalid & s_axi.wready;
    assign ar_hs  = s_axi.arvalid & s_axi.arready;
    assign wr_en  = (wr_state_q == StWrExec);
    assign ar_idx = s_axi.araddr[4:2];

    assign rx_not_empty = (count_q != '0);
    assign rx_full      = (count_q == CntW'(RX_FIFO_DEPTH));
    assign rx_level     = 8'(count_q);

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            StWrIdle: begin
                if (aw_hs && w_hs) wr_state_d = StWrExec;
                else if (aw_hs)    wr_state_d = StWrGotAw;
                else if (w_hs)     wr_state_d = StWrGotW;
            end
            StWrGotAw: if (w_hs) wr_state_d = StWrExec;
            StWrGotW:  if (aw_hs) wr_state_d = StWrExec;
            StWrExec:  wr_state_d = StWrResp;
            StWrResp:  if (s_axi.bready) wr_state_d = StWrIdle;
            default:   wr_state_d = StWrIdle;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            StRdIdle: if (ar_hs) rd_state_d = StRdResp;
            StRdResp: if (s_axi.rready) rd_state_d = StRdIdle;
            default:  rd_state_d = StRdIdle;
        endcase
    end

    // Register write decode, applied in the single StWrExec cycle.
    always_comb begin
        wr_err  = 1'b0;
        baud_d  = baud_q;
        ctrl_d  = ctrl_q;
        flush   = 1'b0;
        ovr_clr = 1'b0;
        tx_load = 1'b0;
        if (wr_en) begin
            case (wr_idx_q)
                3'd0: begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb_q[b]) baud_d[8*b +: 8] = wdata_q[8*b +: 8];
                    end
                end
                3'd1: begin
                    ctrl_d = wdata_q[2:0];
                    flush  = wdata_q[3];
                end
                3'd2: ovr_clr = wdata_q[1];
                3'd3: wr_err = 1'b0;
                3'd4: begin
                    if (wstrb_q[0] && !tx_valid_q) tx_load = 1'b1;
                    else                           wr_err  = 1'b1;
                end
                default: wr_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (ar_idx)
            3'd0: rd_data = baud_q;
            3'd1: rd_data = {29'd0, ctrl_q};
            3'd2: rd_data = {16'd0, rx_level, 4'd0, tx_valid_q, rx_full, overrun_q, rx_not_empty};
            3'd3: if (rx_not_empty) rd_data = {{(32 - DATA_WIDTH){1'b0}}, fifo_mem[rd_ptr_q]};
            3'd4: rd_data = '0;
            default: rd_err = 1'b1;
        endcase
    end

    // A pop frees a slot in the same cycle, so a simultaneous push into a full FIFO is kept.
    assign pop      = ar_hs && (ar_idx == 3'd3) && rx_not_empty;
    assign push_req = rx_valid & ctrl_q[0];
    assign push_do  = push_req & (~rx_full | pop) & ~flush;
    assign ovr_set  = push_req & rx_full & ~pop & ~flush;

    always_comb begin
        count_d = count_q;
        if (flush)                count_d = '0;
        else if (push_do && !pop) count_d = count_q + CntW'(1);
        else if (pop && !push_do) count_d = count_q - CntW'(1);
    end

    always_comb begin
        overrun_d = overrun_q;
        if (ovr_clr) overrun_d = 1'b0;
        if (ovr_set) overrun_d = 1'b1;
        tx_valid_d = tx_valid_q;
        if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;
        if (tx_load) tx_valid_d = 1'b1;
        tx_data_d = tx_load ? wdata_q[DATA_WIDTH-1:0] : tx_data_q;
        irq_d     = (ctrl_q[1] & rx_not_empty) | (ctrl_q[2] & overrun_q);
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wr_state_q <= StWrIdle;
            rd_state_q <= StRdIdle;
            wr_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= 2'b00;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            baud_q     <= BAUD_RESET;
            ctrl_q     <= '0;
            overrun_q  <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            irq_q      <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            if (aw_hs) wr_idx_q <= s_axi.awaddr[4:2];
            if (w_hs) begin
                wdata_q <= s_axi.wdata;
                wstrb_q <= s_axi.wstrb;
            end
            if (wr_en) bresp_q <= {wr_err, 1'b0};
            if (ar_hs) begin
                rdata_q <= rd_data;
                rresp_q <= {rd_err, 1'b0};
            end
            baud_q     <= baud_d;
            ctrl_q     <= ctrl_d;
            overrun_q  <= overrun_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            irq_q      <= irq_d;
            count_q    <= count_d;
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push_do) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (push_do) fifo_mem[wr_ptr_q] <= rx_data;
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign baud_div = baud_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_axils_uart_regs.sv
// Self-checking bench for axils_uart_regs: directed vector table, hand-written
// corner sequences, then random traffic against a queue-based reference model.
module tb_axils_uart_regs;
    localparam int KRd = 0;
    localparam int KWr = 1;
    localparam int KPush = 2;

    typedef struct {
        int          kind;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [31:0] baud_div;
    logic       irq;

    int total = 0;
    int bad = 0;

    axils_uart_regs_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) s_axi ();

    axils_uart_regs dut (
        .S_AXI_ACLK  (clk),
        .S_AXI_ARESET(rst),
        .s_axi       (s_axi),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .baud_div    (baud_div),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int  n;
        logic aw_hit, w_hit;
        @(negedge clk);
        s_axi.awaddr = a; s_axi.awvalid = 1'b1;
        s_axi.wdata = d; s_axi.wstrb = s; s_axi.wvalid = 1'b1;
        s_axi.bready = 1'b1;
        n = 0;
        while ((s_axi.awvalid || s_axi.wvalid) && n < 20) begin
            aw_hit = s_axi.awvalid & s_axi.awready;
            w_hit  = s_axi.wvalid & s_axi.wready;
            @(negedge clk);
            if (aw_hit) s_axi.awvalid = 1'b0;
            if (w_hit)  s_axi.wvalid = 1'b0;
            n++;
        end
        n = 0;
        while (!s_axi.bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b_valid", 32'(s_axi.bvalid), 32'd1);
        resp = s_axi.bresp;
        @(negedge clk);
        s_axi.bready = 1'b0; s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        @(negedge clk);
        s_axi.araddr = a; s_axi.arvalid = 1'b1; s_axi.rready = 1'b1;
        n = 0;
        while (!s_axi.arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        s_axi.arvalid = 1'b0;
        n = 0;
        while (!s_axi.rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("r_valid", 32'(s_axi.rvalid), 32'd1);
        d = s_axi.rdata;
        r = s_axi.rresp;
        @(negedge clk);
        s_axi.rready = 1'b0;
        chk("ar_ready_back", 32'(s_axi.arready), 32'd1);
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    function automatic vec_t mk(input int k, input logic [4:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] ed, input logic [1:0] er);
        vec_t v;
        v.kind = k; v.addr = a; v.data = d; v.strb = s; v.exp_data = ed; v.exp_resp = er;
        return v;
    endfunction

    vec_t        vecs[$];
    logic [31:0] rd, exp_d, d;
    logic [1:0]  rs, exp_r;
    logic [3:0]  s;
    logic [2:0]  idx;
    logic [7:0]  b;
    int          op;
    // Reference model state
    logic [31:0] m_baud;
    logic [2:0]  m_ctrl;
    logic [7:0]  m_q[$];
    logic        m_ovr, m_txv;
    logic [7:0]  m_txd;

    initial begin
        s_axi.awaddr = '0; s_axi.awvalid = 1'b0; s_axi.wdata = '0; s_axi.wstrb = '0;
        s_axi.wvalid = 1'b0; s_axi.bready = 1'b0; s_axi.araddr = '0; s_axi.arvalid = 1'b0;
        s_axi.rready = 1'b0;

        vecs.push_back(mk(KRd,   5'h00, 32'h0,        4'h0, 32'd9600,     2'b00));
        vecs.push_back(mk(KRd,   5'h04, 32'h0,        4'h0, 32'h0,        2'b00));
        vecs.push_back(mk(KRd,   5'h08, 32'h0,        4'h0, 32'h0,        2'b00));
        vecs.push_back(mk(KWr,   5'h04, 32'h1,        4'hF, 32'h0,        2'b00));
        vecs.push_back(mk(KPush, 5'h00, 32'h41,       4'h0, 32'h0,        2'b00));
        vecs.push_back(mk(KPush, 5'h00, 32'h42,       4'h0, 32'h0,        2'b00));
        vecs.push_back(mk(KPush, 5'h00, 32'h43,       4'h0, 32'h0,        2'b00));
        vecs.push_back(mk(KRd,   5'h08, 32'h0,        4'h0, 32'h0301,     2'b00));
        vecs.push_back(mk(KRd,   5'h0C, 32'h0,        4'h0, 32'h41,       2'b00));
        vecs.push_back(mk(KRd,   5'h0C, 32'h0,        4'h0, 32'h42,       2'b00));
        vecs.push_back(mk(KRd,   5'h0C, 32'h0,        4'h0, 32'h43,       2'b00));
        vecs.push_back(mk(KRd,   5'h0C, 32'h0,        4'h0, 32'h0,        2'b00));
        vecs.push_back(mk(KRd,   5'h05, 32'h0,        4'h0, 32'h1,        2'b00));
        vecs.push_back(mk(KRd,   5'h14, 32'h0,        4'h0, 32'h0,        2'b10));
        vecs.push_back(mk(KWr,   5'h1C, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10));
        vecs.push_back(mk(KWr,   5'h00, 32'h12345678, 4'h5, 32'h0,        2'b00));
        vecs.push_back(mk(KRd,   5'h00, 32'h0,        4'h0, 32'h00342578, 2'b00));
        vecs.push_back(mk(KWr,   5'h10, 32'h55,       4'hF, 32'h0,        2'b00));
        vecs.push_back(mk(KWr,   5'h10, 32'h66,       4'hF, 32'h0,        2'b10));
        vecs.push_back(mk(KRd,   5'h08, 32'h0,        4'h0, 32'h8,        2'b00));
        vecs.push_back(mk(KRd,   5'h10, 32'h0,        4'h0, 32'h0,        2'b00));

        repeat (3) @(negedge clk);
        chk("reset_awready", 32'(s_axi.awready), 32'd1);
        chk("reset_bvalid", 32'(s_axi.bvalid), 32'd0);
        chk("reset_baud", baud_div, 32'd9600);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].kind)
                KRd: begin
                    axi_read(vecs[i].addr, rd, rs);
                    chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                    chk($sformatf("vec%0d_rresp", i), 32'(rs), 32'(vecs[i].exp_resp));
                end
                KWr: begin
                    axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
                    chk($sformatf("vec%0d_bresp", i), 32'(rs), 32'(vecs[i].exp_resp));
                end
                default: push(vecs[i].data[7:0]);
            endcase
        end

        // TX holding register
        chk("tx_valid_held", 32'(tx_valid), 32'd1);
        chk("tx_data_kept", 32'(tx_data), 32'h55);
        chk("baud_mirror", baud_div, 32'h00342578);
        @(negedge clk); tx_ready = 1'b1;
        @(negedge clk);
        chk("tx_valid_cleared", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;
        axi_write(5'h10, 32'h77, 4'hE, rs);
        chk("tx_nostrb_bresp", 32'(rs), 32'h2);
        chk("tx_nostrb_valid", 32'(tx_valid), 32'd0);

        // Overflow, W1C and pop+push while full
        for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
        axi_read(5'h08, rd, rs);
        chk("ovf_status", rd, 32'h1007);
        axi_write(5'h08, 32'h2, 4'hF, rs);
        axi_read(5'h08, rd, rs);
        chk("w1c_status", rd, 32'h1005);
        @(negedge clk);
        s_axi.araddr = 5'h0C; s_axi.arvalid = 1'b1; s_axi.rready = 1'b1;
        rx_data = 8'hAA; rx_valid = 1'b1;
        @(negedge clk);
        s_axi.arvalid = 1'b0; rx_valid = 1'b0;
        chk("popush_rvalid", 32'(s_axi.rvalid), 32'd1);
        chk("popush_rdata", s_axi.rdata, 32'h10);
        @(negedge clk);
        s_axi.rready = 1'b0;
        axi_read(5'h08, rd, rs);
        chk("popush_status", rd, 32'h1005);
        for (int i = 0; i < 16; i++) begin
            axi_read(5'h0C, rd, rs);
            chk($sformatf("drain%0d", i), rd, (i < 15) ? 32'(8'h11 + i) : 32'hAA);
        end
        axi_read(5'h08, rd, rs);
        chk("drained_status", rd, 32'h0);

        // AW three cycles ahead of W, BREADY stalled
        @(negedge clk);
        s_axi.awaddr = 5'h00; s_axi.awvalid = 1'b1;
        @(negedge clk);
        s_axi.awvalid = 1'b0;
        chk("aw_only_awready", 32'(s_axi.awready), 32'd0);
        chk("aw_only_wready", 32'(s_axi.wready), 32'd1);
        repeat (2) @(negedge clk);
        s_axi.wdata = 32'h0000CAFE; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
        @(negedge clk);
        s_axi.wvalid = 1'b0;
        s_axi.awaddr = 5'h04; s_axi.awvalid = 1'b1;
        s_axi.wdata = 32'h6; s_axi.wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("bhold%0d_bvalid", i), 32'(s_axi.bvalid), 32'd1);
            chk($sformatf("bhold%0d_awready", i), 32'(s_axi.awready), 32'd0);
            chk($sformatf("bhold%0d_wready", i), 32'(s_axi.wready), 32'd0);
        end
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b1;
        @(negedge clk);
        s_axi.bready = 1'b0;
        chk("bdone_bvalid", 32'(s_axi.bvalid), 32'd0);
        chk("bdone_awready", 32'(s_axi.awready), 32'd1);
        chk("split_baud", baud_div, 32'h0000CAFE);
        axi_read(5'h04, rd, rs);
        chk("no_second_write", rd, 32'h1);

        // Interrupt and flush
        axi_write(5'h04, 32'h7, 4'hF, rs);
        chk("irq_idle", 32'(irq), 32'd0);
        push(8'h5A);
        chk("irq_not_yet", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_rise", 32'(irq), 32'd1);
        axi_write(5'h04, 32'hF, 4'hF, rs);
        axi_read(5'h08, rd, rs);
        chk("flush_status", rd, 32'h0);
        chk("flush_irq", 32'(irq), 32'd0);
        axi_read(5'h04, rd, rs);
        chk("flush_reads0", rd, 32'h7);

        // Reset in the middle of a read
        push(8'h33);
        @(negedge clk);
        s_axi.araddr = 5'h00; s_axi.arvalid = 1'b1; s_axi.rready = 1'b0;
        @(negedge clk);
        s_axi.arvalid = 1'b0;
        chk("midread_rvalid", 32'(s_axi.rvalid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_rvalid", 32'(s_axi.rvalid), 32'd0);
        chk("rst_arready", 32'(s_axi.arready), 32'd1);
        chk("rst_baud", baud_div, 32'd9600);
        @(negedge clk);
        rst = 1'b0;
        axi_read(5'h00, rd, rs);
        chk("post_rst_baud", rd, 32'd9600);
        axi_read(5'h04, rd, rs);
        chk("post_rst_ctrl", rd, 32'h0);
        axi_read(5'h08, rd, rs);
        chk("post_rst_status", rd, 32'h0);

        // Random traffic against the reference model
        m_baud = 32'd9600; m_ctrl = '0; m_q.delete(); m_ovr = 1'b0; m_txv = 1'b0; m_txd = '0;
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                b = 8'($urandom);
                push(b);
                if (m_ctrl[0]) begin
                    if (m_q.size() < 16) m_q.push_back(b);
                    else                 m_ovr = 1'b1;
                end
            end else if (op <= 6) begin
                idx = ($urandom_range(0, 2) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
                axi_read({idx, 2'($urandom)}, rd, rs);
                exp_d = '0; exp_r = 2'b00;
                case (idx)
                    3'd0: exp_d = m_baud;
                    3'd1: exp_d = {29'd0, m_ctrl};
                    3'd2: exp_d = {16'd0, 8'(m_q.size()), 4'd0, m_txv, (m_q.size() == 16),
                                   m_ovr, (m_q.size() != 0)};
                    3'd3: if (m_q.size() != 0) exp_d = {24'd0, m_q.pop_front()};
                    3'd4: exp_d = '0;
                    default: exp_r = 2'b10;
                endcase
                chk($sformatf("rnd%0d_rd%0d_data", it, idx), rd, exp_d);
                chk($sformatf("rnd%0d_rd%0d_resp", it, idx), 32'(rs), 32'(exp_r));
            end else if (op <= 8) begin
                idx = 3'($urandom_range(0, 7));
                d = $urandom;
                s = 4'($urandom);
                if (idx == 3'd1) begin
                    d = {28'd0, ($urandom_range(0, 5) == 0), 2'($urandom),
                         ($urandom_range(0, 4) != 0)};
                end
                axi_write({idx, 2'($urandom)}, d, s, rs);
                exp_r = 2'b00;
                case (idx)
                    3'd0: for (int k = 0; k < 4; k++) if (s[k]) m_baud[8*k +: 8] = d[8*k +: 8];
                    3'd1: begin
                        m_ctrl = d[2:0];
                        if (d[3]) m_q.delete();
                    end
                    3'd2: if (d[1]) m_ovr = 1'b0;
                    3'd3: exp_r = 2'b00;
                    3'd4: begin
                        if (s[0] && !m_txv) begin
                            m_txv = 1'b1;
                            m_txd = d[7:0];
                        end else begin
                            exp_r = 2'b10;
                        end
                    end
                    default: exp_r = 2'b10;
                endcase
                chk($sformatf("rnd%0d_wr%0d_resp", it, idx), 32'(rs), 32'(exp_r));
            end else begin
                @(negedge clk); tx_ready = 1'b1;
                @(negedge clk); tx_ready = 1'b0;
                m_txv = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("rnd%0d_irq", it), 32'(irq),
                32'((m_ctrl[1] && m_q.size() != 0) || (m_ctrl[2] && m_ovr)));
            chk($sformatf("rnd%0d_txv", it), 32'(tx_valid), 32'(m_txv));
            chk($sformatf("rnd%0d_baud", it), baud_div, m_baud);
            if (m_txv) chk($sformatf("rnd%0d_txd", it), 32'(tx_data), 32'(m_txd));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
